// File: rtl/dataflow_ctrl_pkg.sv
// Shared types and helpers for the dataflow start/continue controller.
package dataflow_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } ctrl_state_e;

    localparam int STALL_LIMIT_DEFAULT = 1024;

    // Bits needed to hold a token count of 0..depth inclusive.
    function automatic int tok_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/start_token_counter.sv
// Occupancy counter for the start-token FIFO between producer and consumer.
module start_token_counter
    import dataflow_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = tok_cnt_w(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    output logic         full_n,
    output logic         empty_n,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] FULL = W'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !pop && count != FULL) begin
            count <= count + 1'b1;
        end else if (pop && !push && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Status reads as empty while reset is held so nothing launches from stale tokens.
    assign full_n  = rst | (count != FULL);
    assign empty_n = ~rst & (count != '0);

endmodule

// File: rtl/dataflow_start_ctrl.sv
// Block-level ap_ctrl sequencer for a two-process dataflow region (producer p0, consumer p1).
module dataflow_start_ctrl
    import dataflow_ctrl_pkg::*;
#(
    parameter int START_DEPTH = 2,
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst,
    input  logic                                ap_start,
    input  logic                                ap_continue,
    output logic                                ap_ready,
    output logic                                ap_done,
    output logic                                ap_idle,
    output logic                                p0_ap_start,
    output logic                                p0_ap_continue,
    input  logic                                p0_ap_ready,
    input  logic                                p0_ap_done,
    input  logic                                p0_ap_idle,
    output logic                                p1_ap_start,
    output logic                                p1_ap_continue,
    input  logic                                p1_ap_ready,
    input  logic                                p1_ap_done,
    input  logic                                p1_ap_idle,
    output logic                                start_full_n,
    output logic                                start_empty_n,
    output logic [CNT_W-1:0]                    trans_in_cnt,
    output logic [CNT_W-1:0]                    trans_out_cnt,
    output logic                                stall_flag,
    output ctrl_state_e                         state,
    output logic [tok_cnt_w(START_DEPTH)-1:0]   tok_cnt
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    logic             launch, pop, retire, progress;
    logic             done_hold, done_hold_d, hold_vis;
    logic [CNT_W-1:0] in_d, out_d;
    logic [SW-1:0]    stall_cnt, stall_d;
    ctrl_state_e      state_d;
    logic             unused;

    // Handshakes: a transfer happens in exactly the cycle where start and ready are both high.
    assign p0_ap_start    = ap_start & start_full_n;
    assign launch         = p0_ap_start & p0_ap_ready;
    assign ap_ready       = launch;
    assign p1_ap_start    = start_empty_n;
    assign pop            = start_empty_n & p1_ap_ready;
    assign p0_ap_continue = 1'b1;
    assign p1_ap_continue = ap_continue;
    assign unused         = p0_ap_done;

    start_token_counter #(.DEPTH(START_DEPTH)) u_tokens (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .push    (launch),
        .pop     (pop),
        .full_n  (start_full_n),
        .empty_n (start_empty_n),
        .count   (tok_cnt)
    );

    assign hold_vis    = done_hold & ~ap_rst;
    assign ap_done     = p1_ap_done | hold_vis;
    assign ap_idle     = p0_ap_idle & p1_ap_idle & ~start_empty_n & ~hold_vis;
    assign retire      = ap_done & ap_continue;
    assign done_hold_d = ap_continue ? 1'b0 : (p1_ap_done | done_hold);
    assign in_d        = trans_in_cnt + CNT_W'(launch);
    assign out_d       = trans_out_cnt + CNT_W'(retire);
    assign progress    = launch | pop | p1_ap_done;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (launch) state_d = BUSY;
            BUSY:    if (done_hold_d) state_d = HOLD;
                     else if (in_d == out_d) state_d = IDLE;
            HOLD:    if (ap_continue) state_d = (in_d != out_d) ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_d = '0;
        if (state == BUSY && !progress) begin
            stall_d = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= IDLE;
            done_hold     <= 1'b0;
            trans_in_cnt  <= '0;
            trans_out_cnt <= '0;
            stall_cnt     <= '0;
            stall_flag    <= 1'b0;
        end else begin
            state         <= state_d;
            done_hold     <= done_hold_d;
            trans_in_cnt  <= in_d;
            trans_out_cnt <= out_d;
            stall_cnt     <= stall_d;
            if (stall_d == STALL_MAX) stall_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dataflow_start_ctrl.sv
// Self-checking bench for dataflow_start_ctrl: directed scenarios plus a randomized run against a cycle model.
module tb_dataflow_start_ctrl;
    import dataflow_ctrl_pkg::*;

    localparam int DEPTH = 3;
    localparam int CW    = 16;
    localparam int SL    = 8;

    logic ap_clk = 1'b0;
    logic ap_rst, ap_start, ap_continue;
    logic ap_ready, ap_done, ap_idle;
    logic p0_ap_start, p0_ap_continue, p0_ap_ready, p0_ap_done, p0_ap_idle;
    logic p1_ap_start, p1_ap_continue, p1_ap_ready, p1_ap_done, p1_ap_idle;
    logic start_full_n, start_empty_n, stall_flag;
    logic [CW-1:0] trans_in_cnt, trans_out_cnt;
    ctrl_state_e state;
    logic [1:0] tok_cnt;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    dataflow_start_ctrl #(.START_DEPTH(DEPTH), .CNT_W(CW), .STALL_LIMIT(SL)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .p0_ap_start(p0_ap_start), .p0_ap_continue(p0_ap_continue), .p0_ap_ready(p0_ap_ready),
        .p0_ap_done(p0_ap_done), .p0_ap_idle(p0_ap_idle),
        .p1_ap_start(p1_ap_start), .p1_ap_continue(p1_ap_continue), .p1_ap_ready(p1_ap_ready),
        .p1_ap_done(p1_ap_done), .p1_ap_idle(p1_ap_idle),
        .start_full_n(start_full_n), .start_empty_n(start_empty_n),
        .trans_in_cnt(trans_in_cnt), .trans_out_cnt(trans_out_cnt),
        .stall_flag(stall_flag), .state(state), .tok_cnt(tok_cnt)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ap_start = 0; ap_continue = 0;
        p0_ap_ready = 0; p0_ap_done = 0; p0_ap_idle = 1;
        p1_ap_ready = 0; p1_ap_done = 0; p1_ap_idle = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        ap_rst = 1;
        tick();
        ap_rst = 0;
    endtask

    task automatic launch_cycle();
        ap_start = 1; p0_ap_ready = 1;
        tick();
        ap_start = 0; p0_ap_ready = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        p1_ap_ready = 0;
        launch_cycle();
        ap_rst = 1;
        #1;
        checks++;
        if (start_full_n !== 1'b1 || start_empty_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: full_n=%b empty_n=%b required 1 0", start_full_n, start_empty_n);
        end
        tick();
        ap_rst = 0;
        #1;
        checks++;
        if (tok_cnt !== 2'd0 || trans_in_cnt !== 16'd0 || trans_out_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: tok=%0d in=%0d out=%0d required 0 0 0", tok_cnt, trans_in_cnt, trans_out_cnt);
        end
        checks++;
        if (state !== IDLE || stall_flag !== 1'b0 || ap_idle !== 1'b1 || ap_done !== 1'b0 || p0_ap_continue !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: state=%0d stall=%b idle=%b done=%b p0_cont=%b required 0 0 1 0 1",
                     state, stall_flag, ap_idle, ap_done, p0_ap_continue);
        end
    endtask

    task automatic test_fill();
        int exp_tok;
        do_reset();
        ap_start = 1; p1_ap_ready = 0;
        for (int i = 0; i <= DEPTH; i++) begin
            p0_ap_ready = 1;
            #1;
            checks++;
            if (p0_ap_start !== (i < DEPTH) || ap_ready !== (i < DEPTH)) begin
                errors++;
                $display("FAIL fill_launch%0d: p0_start=%b ap_ready=%b required %b", i, p0_ap_start, ap_ready, i < DEPTH);
            end
            tick();
            p0_ap_ready = 0;
            exp_tok = (i + 1 < DEPTH) ? i + 1 : DEPTH;
            checks++;
            if (tok_cnt !== 2'(exp_tok)) begin
                errors++;
                $display("FAIL fill_tok%0d: tok=%0d required %0d", i, tok_cnt, exp_tok);
            end
            tick();
        end
        checks++;
        if (start_full_n !== 1'b0 || start_empty_n !== 1'b1 || trans_in_cnt !== 16'(DEPTH) || state !== BUSY) begin
            errors++;
            $display("FAIL fill_end: full_n=%b empty_n=%b in=%0d state=%0d required 0 1 %0d 1",
                     start_full_n, start_empty_n, trans_in_cnt, state, DEPTH);
        end
        idle_inputs();
    endtask

    task automatic test_push_pop();
        do_reset();
        launch_cycle();
        launch_cycle();
        ap_start = 1; p0_ap_ready = 1; p1_ap_ready = 1;
        tick();
        checks++;
        if (tok_cnt !== 2'd2 || trans_in_cnt !== 16'd3) begin
            errors++;
            $display("FAIL push_pop_mid: tok=%0d in=%0d required 2 3", tok_cnt, trans_in_cnt);
        end
        p1_ap_ready = 0;
        tick();
        p1_ap_ready = 1;
        #1;
        checks++;
        if (ap_ready !== 1'b0 || p1_ap_start !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_full: ap_ready=%b p1_start=%b required 0 1", ap_ready, p1_ap_start);
        end
        tick();
        checks++;
        if (tok_cnt !== 2'd2 || trans_in_cnt !== 16'd4) begin
            errors++;
            $display("FAIL push_pop_at_full: tok=%0d in=%0d required 2 4", tok_cnt, trans_in_cnt);
        end
        ap_start = 0; p0_ap_ready = 0;
        tick();
        tick();
        tick();
        checks++;
        if (tok_cnt !== 2'd0 || start_empty_n !== 1'b0 || p1_ap_start !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_drain: tok=%0d empty_n=%b p1_start=%b required 0 0 0", tok_cnt, start_empty_n, p1_ap_start);
        end
        idle_inputs();
    endtask

    task automatic test_done_hold();
        int high = 0;
        do_reset();
        launch_cycle();
        p1_ap_done = 1; ap_continue = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ap_done === 1'b1) high++;
            tick();
        end
        checks++;
        if (state !== HOLD || p1_ap_continue !== 1'b0) begin
            errors++;
            $display("FAIL done_hold_state: state=%0d p1_cont=%b required 2 0", state, p1_ap_continue);
        end
        ap_continue = 1;
        #1;
        if (ap_done === 1'b1) high++;
        tick();
        checks++;
        if (trans_out_cnt !== 16'd1 || state !== IDLE) begin
            errors++;
            $display("FAIL done_hold_release: out=%0d state=%0d required 1 0", trans_out_cnt, state);
        end
        p1_ap_done = 0;
        #1;
        if (ap_done === 1'b1) high++;
        tick();
        checks++;
        if (high != 5 || trans_out_cnt !== 16'd1) begin
            errors++;
            $display("FAIL done_hold_count: done_cycles=%0d out=%0d required 5 1", high, trans_out_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        launch_cycle();
        for (int k = 1; k <= SL; k++) begin
            tick();
            if (k == SL - 1) begin
                checks++;
                if (stall_flag !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_early: flag=%b required 0 after %0d idle cycles", stall_flag, k);
                end
            end
        end
        checks++;
        if (stall_flag !== 1'b1) begin
            errors++;
            $display("FAIL stall_set: flag=%b required 1", stall_flag);
        end
        p1_ap_ready = 1;
        tick();
        p1_ap_ready = 0;
        tick();
        tick();
        checks++;
        if (stall_flag !== 1'b1 || tok_cnt !== 2'd0) begin
            errors++;
            $display("FAIL stall_sticky: flag=%b tok=%0d required 1 0", stall_flag, tok_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        launch_cycle();
        launch_cycle();
        p1_ap_done = 1; ap_continue = 0;
        tick();
        p1_ap_done = 0;
        #1;
        checks++;
        if (ap_done !== 1'b1 || tok_cnt !== 2'd2) begin
            errors++;
            $display("FAIL rst_mid_pre: done=%b tok=%0d required 1 2", ap_done, tok_cnt);
        end
        ap_rst = 1;
        #1;
        checks++;
        if (start_full_n !== 1'b1 || start_empty_n !== 1'b0 || ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_during: full_n=%b empty_n=%b done=%b idle=%b required 1 0 0 1",
                     start_full_n, start_empty_n, ap_done, ap_idle);
        end
        tick();
        ap_rst = 0;
        #1;
        checks++;
        if (tok_cnt !== 2'd0 || trans_in_cnt !== 16'd0 || trans_out_cnt !== 16'd0 || state !== IDLE || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after: tok=%0d in=%0d out=%0d state=%0d idle=%b required 0 0 0 0 1",
                     tok_cnt, trans_in_cnt, trans_out_cnt, state, ap_idle);
        end
        p1_ap_idle = 0;
        #1;
        checks++;
        if (ap_idle !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: idle=%b required 0", ap_idle);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int m_tok, m_in, m_out, m_stall;
        bit m_hold, m_flag, e_full, e_empty, e_hv, e_p0s, e_launch, e_pop, e_done, e_idle, hold_n;
        ctrl_state_e m_st;
        logic [8:0] got_c, exp_c;
        do_reset();
        m_tok = 0; m_in = 0; m_out = 0; m_stall = 0; m_hold = 0; m_flag = 0; m_st = IDLE;
        for (int n = 0; n < 600; n++) begin
            ap_rst      = ($urandom_range(0, 59) == 0);
            ap_start    = ($urandom_range(0, 3) != 0);
            p0_ap_ready = $urandom_range(0, 1) == 1;
            p1_ap_ready = ($urandom_range(0, 2) == 0);
            p1_ap_done  = ($urandom_range(0, 5) == 0);
            ap_continue = ($urandom_range(0, 2) != 0);
            p0_ap_idle  = $urandom_range(0, 1) == 1;
            p1_ap_idle  = $urandom_range(0, 1) == 1;
            #1;
            e_full   = ap_rst ? 1'b1 : (m_tok != DEPTH);
            e_empty  = ap_rst ? 1'b0 : (m_tok != 0);
            e_hv     = ap_rst ? 1'b0 : m_hold;
            e_p0s    = ap_start && e_full;
            e_launch = e_p0s && p0_ap_ready;
            e_pop    = e_empty && p1_ap_ready;
            e_done   = p1_ap_done || e_hv;
            e_idle   = p0_ap_idle && p1_ap_idle && !e_empty && !e_hv;
            got_c = {p0_ap_start, ap_ready, p1_ap_start, start_full_n, start_empty_n, ap_done, ap_idle, p1_ap_continue, p0_ap_continue};
            exp_c = {e_p0s, e_launch, e_empty, e_full, e_empty, e_done, e_idle, ap_continue, 1'b1};
            checks++;
            if (got_c !== exp_c) begin
                errors++;
                $display("FAIL rand_comb%0d: got=%b required %b", n, got_c, exp_c);
            end
            checks++;
            if (tok_cnt !== 2'(m_tok) || trans_in_cnt !== 16'(m_in) || trans_out_cnt !== 16'(m_out)
                || state !== m_st || stall_flag !== m_flag) begin
                errors++;
                $display("FAIL rand_state%0d: tok=%0d in=%0d out=%0d st=%0d flag=%b required %0d %0d %0d %0d %b",
                         n, tok_cnt, trans_in_cnt, trans_out_cnt, state, stall_flag, m_tok, m_in, m_out, m_st, m_flag);
            end
            if (ap_rst) begin
                m_tok = 0; m_in = 0; m_out = 0; m_stall = 0; m_hold = 0; m_flag = 0; m_st = IDLE;
            end else begin
                m_tok  = m_tok + int'(e_launch) - int'(e_pop);
                m_in   = (m_in + int'(e_launch)) % 65536;
                m_out  = (m_out + int'(e_done && ap_continue)) % 65536;
                hold_n = ap_continue ? 1'b0 : (p1_ap_done || m_hold);
                if (m_st == BUSY && !(e_launch || e_pop || p1_ap_done))
                    m_stall = (m_stall + 1 > SL) ? SL : m_stall + 1;
                else
                    m_stall = 0;
                if (m_stall == SL) m_flag = 1;
                case (m_st)
                    IDLE: if (e_launch) m_st = BUSY;
                    BUSY: if (hold_n) m_st = HOLD; else if (m_in == m_out) m_st = IDLE;
                    default: if (ap_continue) m_st = (m_in != m_out) ? BUSY : IDLE;
                endcase
                m_hold = hold_n;
            end
            tick();
        end
        ap_rst = 0;
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        ap_start = 1; p0_ap_ready = 1; p1_ap_ready = 1; ap_continue = 1;
        for (int i = 0; i < 65535; i++) begin
            p1_ap_done = (i == 10 || i == 20);
            tick();
        end
        checks++;
        if (trans_in_cnt !== 16'hFFFF || trans_out_cnt !== 16'd2 || state !== BUSY) begin
            errors++;
            $display("FAIL wrap_pre: in=%h out=%0d state=%0d required ffff 2 1", trans_in_cnt, trans_out_cnt, state);
        end
        tick();
        checks++;
        if (trans_in_cnt !== 16'h0000 || state !== BUSY || tok_cnt !== 2'd1) begin
            errors++;
            $display("FAIL wrap_post: in=%h state=%0d tok=%0d required 0000 1 1", trans_in_cnt, state, tok_cnt);
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        idle_inputs();
        ap_rst = 1;
        test_reset();
        test_fill();
        test_push_pop();
        test_done_hold();
        test_stall();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
